// File: rtl/tx_frame_scheduler_pkg.sv
// rtl/tx_frame_scheduler_pkg.sv - state encoding, frame field positions and frame timing for tx_frame_scheduler
// Contents: sched_state_t, frame bit-field constants, frame_cycles(len).
package tx_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  localparam int PREAMBLE_BITS = 16;
  localparam int SFD_BITS      = 8;
  localparam int HDR_BITS      = 8;
  localparam int CRC_BITS      = 8;
  localparam int LEN_MSB       = 131;
  localparam int LEN_LSB       = 128;

  // Fixed part includes the first payload byte: the length field encodes (bytes - 1).
  localparam int FRAME_FIXED = PREAMBLE_BITS + SFD_BITS + HDR_BITS + CRC_BITS + 8;

  // Cycles the transmitter is busy serialising one frame: 48 + 8*len (48..168).
  function automatic logic [7:0] frame_cycles(input logic [3:0] len);
    return 8'(FRAME_FIXED) + {1'b0, len, 3'b000};
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// rtl/tx_frame_scheduler_rr_arbiter.sv - combinational round-robin arbiter (module rr_arbiter)
// Ports: req (request vector), ptr (last winner; search starts at ptr+1),
//        grant (one-hot), grant_idx (winner index), any (some request present).
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin : search
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Walk ptr+1, ptr+2, ... wrapping; the first active request wins.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - round-robin scheduler sharing one serial frame transmitter
// Ports: clk, rst (async, active-high); req_valid/req_packet/req_ready (per-port accept);
//        tx_start (active-low strobe), tx_packet; busy, grant_id; done_valid/done_id.
// Build option: TX_SCHED_PRIO_EN gives port 0 strict priority over the round-robin ports.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PKT_W      = 136,
  parameter int IFG_CYCLES = 0,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*PKT_W-1:0] req_packet,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic                       tx_start,
  output logic [PKT_W-1:0]           tx_packet,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       done_valid,
  output logic [IDX_W-1:0]           done_id
);

  sched_state_t         state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] arb_req, arb_grant, win_grant;
  logic [IDX_W-1:0]     arb_idx, win_idx;
  logic                 arb_any, win_any, prio_win;
  logic                 accept, frame_end;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

`ifdef TX_SCHED_PRIO_EN
  // Port 0 bypasses the rotation entirely and never moves the pointer.
  assign prio_win = req_valid[0];
  assign arb_req  = {req_valid[NUM_PORTS-1:1], 1'b0};
`else
  assign prio_win = 1'b0;
  assign arb_req  = req_valid;
`endif

  assign win_grant = prio_win ? NUM_PORTS'(1) : arb_grant;
  assign win_idx   = prio_win ? '0 : arb_idx;
  assign win_any   = prio_win | arb_any;
  assign req_ready = (state == ST_IDLE) ? win_grant : '0;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (win_any) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // No done signal from the transmitter: occupancy is timed from the length field.
        cnt_d   = CNT_W'(frame_cycles(tx_packet[LEN_MSB:LEN_LSB]) - 8'd1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          if (IFG_CYCLES > 0) begin
            cnt_d   = CNT_W'(IFG_CYCLES - 1);
            state_d = ST_GAP;
          end else begin
            frame_end = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      tx_start   <= 1'b1;
      tx_packet  <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      rr_ptr     <= IDX_W'(NUM_PORTS - 1);
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      cnt        <= cnt_d;
      // Low only in the cycle after an accept, i.e. exactly the START cycle.
      tx_start   <= ~accept;
      done_valid <= frame_end;
      if (accept) begin
        tx_packet <= req_packet[win_idx*PKT_W +: PKT_W];
        grant_id  <= win_idx;
        busy      <= 1'b1;
        if (!prio_win) rr_ptr <= win_idx;
      end
      if (frame_end) begin
        busy    <= 1'b0;
        done_id <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - directed self-checking bench for tx_frame_scheduler
module tb_tx_frame_scheduler;
  localparam int NP = 4;
  localparam int PW = 136;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] req_valid, req_ready, req_valid2, req_ready2;
  logic [NP*PW-1:0] req_packet, req_packet2;
  logic tx_start, busy, done_valid, tx_start2, busy2, done_valid2;
  logic [PW-1:0] tx_packet, tx_packet2;
  logic [IW-1:0] grant_id, done_id, grant_id2, done_id2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int st_cyc[$], st_id[$], dn_cyc[$], dn_id[$], acc_cyc[$], st2_cyc[$], dn2_cyc[$];
  logic [PW-1:0] st_pkt[$];

  always #5 clk = ~clk;

  tx_frame_scheduler #(.NUM_PORTS(NP), .PKT_W(PW), .IFG_CYCLES(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_packet(req_packet), .req_ready(req_ready),
    .tx_start(tx_start), .tx_packet(tx_packet), .busy(busy), .grant_id(grant_id),
    .done_valid(done_valid), .done_id(done_id));

  tx_frame_scheduler #(.NUM_PORTS(NP), .PKT_W(PW), .IFG_CYCLES(10), .CNT_W(8)) dut_ifg (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_packet(req_packet2), .req_ready(req_ready2),
    .tx_start(tx_start2), .tx_packet(tx_packet2), .busy(busy2), .grant_id(grant_id2),
    .done_valid(done_valid2), .done_id(done_id2));

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; acc_cyc marks the cycle whose closing edge transfers.
  always @(negedge clk) begin
    if (!tx_start) begin
      st_cyc.push_back(cyc); st_id.push_back(int'(grant_id)); st_pkt.push_back(tx_packet);
    end
    if (done_valid) begin
      dn_cyc.push_back(cyc); dn_id.push_back(int'(done_id));
    end
    if (|(req_valid & req_ready)) acc_cyc.push_back(cyc);
    if (!tx_start2) st2_cyc.push_back(cyc);
    if (done_valid2) dn2_cyc.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] mk_pkt(input int port, input int len);
    logic [3:0] l;
    l = len[3:0];
    return {4'h5, l, 32'hA5A50000 + 32'(port), 96'(port * 1000 + len + 1)};
  endfunction

  task automatic clear_logs();
    st_cyc.delete(); st_id.delete(); st_pkt.delete(); dn_cyc.delete(); dn_id.delete();
    acc_cyc.delete(); st2_cyc.delete(); dn2_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; req_valid2 = '0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && (busy || busy2); k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; req_valid2 = '0;
    @(negedge clk);
    n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL reset_tx_start got %b want 1", tx_start); end
    n_tests++; if (tx_packet !== '0) begin n_fail++; $display("FAIL reset_tx_packet got %h want 0", tx_packet); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    n_tests++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid got %b want 0", done_valid); end
    n_tests++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id got %0d want 0", done_id); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [PW-1:0] p;
    do_reset();
    p = mk_pkt(2, 0);
    req_packet[2*PW +: PW] = p;
    req_valid = 4'b0100;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_after_accept got %b want 1", busy); end
    for (int k = 0; k < 300 && dn_cyc.size() < 1; k++) @(posedge clk);
    #1;
    n_tests++; if (dn_cyc.size() != 1) begin n_fail++; $display("FAIL single_done_count got %0d want 1", dn_cyc.size()); end
    n_tests++; if (st_cyc.size() != 1) begin n_fail++; $display("FAIL single_start_low_cycles got %0d want 1", st_cyc.size()); end
    n_tests++; if (st_cyc[0] != acc_cyc[0] + 1) begin n_fail++; $display("FAIL single_start_latency got %0d want %0d", st_cyc[0], acc_cyc[0] + 1); end
    n_tests++; if (dn_cyc[0] - st_cyc[0] != 49) begin n_fail++; $display("FAIL single_done_delay got %0d want 49", dn_cyc[0] - st_cyc[0]); end
    n_tests++; if (dn_id[0] != 2) begin n_fail++; $display("FAIL single_done_id got %0d want 2", dn_id[0]); end
    n_tests++; if (st_pkt[0] !== p) begin n_fail++; $display("FAIL single_tx_packet got %h want %h", st_pkt[0], p); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_done got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_id[5];
    exp_id = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NP; i++) req_packet[i*PW +: PW] = mk_pkt(i, 3);
    req_valid = 4'b1111;
    for (int k = 0; k < 600 && st_cyc.size() < 5; k++) @(posedge clk);
    #1 req_valid = '0;
    n_tests++; if (st_cyc.size() < 5) begin n_fail++; $display("FAIL rr_start_count got %0d want 5", st_cyc.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (st_id[i] != exp_id[i]) begin n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, st_id[i], exp_id[i]); end
      n_tests++; if (st_pkt[i] !== mk_pkt(exp_id[i], 3)) begin n_fail++; $display("FAIL rr_packet[%0d] got %h want %h", i, st_pkt[i], mk_pkt(exp_id[i], 3)); end
      if (i > 0) begin
        n_tests++; if (st_cyc[i] - st_cyc[i-1] != 74) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want 74", i, st_cyc[i] - st_cyc[i-1]); end
      end
    end
    wait_idle();
  endtask

  task automatic test_max_len();
    do_reset();
    req_packet[1*PW +: PW] = mk_pkt(1, 15);
    req_valid = 4'b0010;
    for (int k = 0; k < 500 && st_cyc.size() < 2; k++) @(posedge clk);
    #1 req_valid = '0;
    n_tests++; if (st_cyc.size() < 2) begin n_fail++; $display("FAIL maxlen_start_count got %0d want 2", st_cyc.size()); end
    n_tests++; if (dn_cyc[0] - st_cyc[0] != 169) begin n_fail++; $display("FAIL maxlen_done_delay got %0d want 169", dn_cyc[0] - st_cyc[0]); end
    n_tests++; if (st_cyc[1] - st_cyc[0] != 170) begin n_fail++; $display("FAIL maxlen_spacing got %0d want 170", st_cyc[1] - st_cyc[0]); end
    wait_idle();
  endtask

  task automatic test_ifg();
    do_reset();
    req_packet2[0*PW +: PW] = mk_pkt(0, 1);
    req_packet2[1*PW +: PW] = mk_pkt(1, 1);
    req_valid2 = 4'b0011;
    for (int k = 0; k < 400 && st2_cyc.size() < 2; k++) @(posedge clk);
    #1 req_valid2 = '0;
    n_tests++; if (st2_cyc.size() < 2) begin n_fail++; $display("FAIL ifg_start_count got %0d want 2", st2_cyc.size()); end
    n_tests++; if (st2_cyc[1] - st2_cyc[0] != 68) begin n_fail++; $display("FAIL ifg_spacing got %0d want 68", st2_cyc[1] - st2_cyc[0]); end
    n_tests++; if (dn2_cyc[0] - st2_cyc[0] != 67) begin n_fail++; $display("FAIL ifg_done_delay got %0d want 67", dn2_cyc[0] - st2_cyc[0]); end
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    do_reset();
    req_packet[2*PW +: PW] = mk_pkt(2, 5);
    req_valid = 4'b0100;
    for (int k = 0; k < 20 && st_cyc.size() < 1; k++) @(posedge clk);
    #1 req_valid = '0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_start got %b want 1", tx_start); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_tests++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_done_valid got %b want 0", done_valid); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    n_tests++; if (dn_cyc.size() != 0) begin n_fail++; $display("FAIL midrst_spurious_done got %0d want 0", dn_cyc.size()); end
    n_tests++; if (st_cyc.size() != 1) begin n_fail++; $display("FAIL midrst_start_count got %0d want 1", st_cyc.size()); end
    clear_logs();
    req_packet[3*PW +: PW] = mk_pkt(3, 0);
    req_valid = 4'b1000;
    for (int k = 0; k < 20 && st_cyc.size() < 1; k++) @(posedge clk);
    #1 req_valid = '0;
    for (int k = 0; k < 100 && dn_cyc.size() < 1; k++) @(posedge clk);
    #1;
    n_tests++; if (st_id[0] != 3) begin n_fail++; $display("FAIL midrst_post_grant got %0d want 3", st_id[0]); end
    n_tests++; if (dn_id[0] != 3) begin n_fail++; $display("FAIL midrst_post_done_id got %0d want 3", dn_id[0]); end
    n_tests++; if (dn_cyc[0] - st_cyc[0] != 49) begin n_fail++; $display("FAIL midrst_post_delay got %0d want 49", dn_cyc[0] - st_cyc[0]); end
  endtask

  task automatic test_two_port();
    int exp_id[4];
`ifdef TX_SCHED_PRIO_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    do_reset();
    req_packet[0*PW +: PW] = mk_pkt(0, 0);
    req_packet[1*PW +: PW] = mk_pkt(1, 0);
    req_valid = 4'b0011;
    for (int k = 0; k < 400 && st_cyc.size() < 4; k++) @(posedge clk);
    #1 req_valid = '0;
    n_tests++; if (st_cyc.size() < 4) begin n_fail++; $display("FAIL two_port_start_count got %0d want 4", st_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (st_id[i] != exp_id[i]) begin n_fail++; $display("FAIL two_port_grant[%0d] got %0d want %0d", i, st_id[i], exp_id[i]); end
    end
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_valid2 = '0;
    req_packet = '0; req_packet2 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_len();
    test_ifg();
    test_reset_midframe();
    test_two_port();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
